// File: rtl/csct_pkg.sv
// Census-transform controller shared types and constants.
// State encoding and coordinate widths used across the block.
package csct_pkg;

  localparam int COORD_W = 13;
  localparam int LB_ADDR_W = 10;
  localparam int WIN = 5;
  localparam logic [7:0] THR_DEFAULT = 8'd8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_ACTIVE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/csct_coord_cnt.sv
// Column/row counter pair for the census controller.
// Holds the coordinate of the next pixel expected in the frame.
module csct_coord_cnt
  import csct_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               adv,
  output logic [COORD_W-1:0] col_q,
  output logic [COORD_W-1:0] row_q,
  output logic               eol,
  output logic               last
);

  assign eol  = col_q == COORD_W'(IMG_W - 1);
  assign last = eol && (row_q == COORD_W'(IMG_H - 1));

  // A frame-start pixel is (0,0), so the next one is (0,1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (start) begin
      col_q <= COORD_W'(1);
      row_q <= '0;
    end else if (adv) begin
      if (eol) begin
        col_q <= '0;
        row_q <= last ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/csct_ctrl.sv
// Census-transform frame controller: frame FSM, coordinates,
// line-buffer write enable, threshold latch and window qualifier.
module csct_ctrl
  import csct_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sof,
  input  logic               pix_valid,
  input  logic [7:0]         thr_in,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               lb_wren,
  output logic [7:0]         thr,
  output logic               win_valid,
  output logic [COORD_W-1:0] ctr_col,
  output logic [COORD_W-1:0] ctr_row,
  output logic               eof,
  output logic               busy,
  output logic               err
);

  state_t             state;
  logic               start;
  logic               in_frame;
  logic               adv;
  logic               hit;
  logic               eol;
  logic               last;
  logic [COORD_W-1:0] col_q;
  logic [COORD_W-1:0] row_q;

  assign start    = sof && pix_valid;
  assign in_frame = (state == S_FILL) || (state == S_ACTIVE);
  assign adv      = pix_valid && in_frame;

  csct_coord_cnt #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .adv  (adv),
    .col_q(col_q),
    .row_q(row_q),
    .eol  (eol),
    .last (last)
  );

  assign col = (state == S_IDLE || start) ? '0 : col_q;
  assign row = (state == S_IDLE || start) ? '0 : row_q;

  assign lb_wren = pix_valid
                && (in_frame || (state == S_IDLE && sof));
  assign busy = state != S_IDLE;

  assign hit = lb_wren
            && row >= COORD_W'(WIN - 1)
            && col >= COORD_W'(WIN - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      thr       <= THR_DEFAULT;
      err       <= 1'b0;
      eof       <= 1'b0;
      win_valid <= 1'b0;
      ctr_col   <= '0;
      ctr_row   <= '0;
    end else begin
      eof       <= 1'b0;
      win_valid <= hit;
      if (hit) begin
        ctr_col <= col - COORD_W'(2);
        ctr_row <= row - COORD_W'(2);
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FILL;
            thr   <= thr_in;
          end
        end
        S_FILL, S_ACTIVE: begin
          if (start) begin
            err   <= 1'b1;
            state <= S_FILL;
            thr   <= thr_in;
          end else if (adv) begin
            if (state == S_FILL && eol
                && row_q == COORD_W'(WIN - 2))
              state <= S_ACTIVE;
            else if (state == S_ACTIVE && last) begin
              state <= S_DONE;
              eof   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            err   <= 1'b1;
            state <= S_FILL;
            thr   <= thr_in;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csct_ctrl.sv
// Randomized and directed bench for csct_ctrl against a
// pixel-index frame model.
module tb_csct_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic [7:0]  thr_in = 8'd0;
  logic [12:0] col, row, ctr_col, ctr_row;
  logic        lb_wren, win_valid, eof, busy, err;
  logic [7:0]  thr;

  logic        w_sof = 1'b0;
  logic        w_pv = 1'b0;
  logic [12:0] w_col, w_row, w_cc, w_cr;
  logic        w_lb, w_wv, w_eof, w_busy, w_err;
  logic [7:0]  w_thr;

  int nchk = 0;
  int nbad = 0;

  // model: phase 0=idle 1=in frame 2=done, n=next pixel index
  int ph, n, m_cc, m_cr, m_thr;
  bit m_win, m_err;
  int wcnt;

  always #5 clk = ~clk;

  csct_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(5)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof),
    .pix_valid(pix_valid), .thr_in(thr_in),
    .col(col), .row(row), .lb_wren(lb_wren),
    .thr(thr), .win_valid(win_valid),
    .ctr_col(ctr_col), .ctr_row(ctr_row),
    .eof(eof), .busy(busy), .err(err)
  );

  csct_ctrl #(.IMG_W(1024), .IMG_H(8), .WIN(5)) u_wide (
    .clk(clk), .rst_n(rst_n), .sof(w_sof),
    .pix_valid(w_pv), .thr_in(8'd1),
    .col(w_col), .row(w_row), .lb_wren(w_lb),
    .thr(w_thr), .win_valid(w_wv),
    .ctr_col(w_cc), .ctr_row(w_cr),
    .eof(w_eof), .busy(w_busy), .err(w_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; n = 0; m_cc = 0; m_cr = 0;
    m_thr = 8; m_win = 0; m_err = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sof = 1'b0;
    pix_valid = 1'b0;
    #1;
    model_reset();
    check("rst_busy", busy, 0);
    check("rst_win", win_valid, 0);
    check("rst_eof", eof, 0);
    check("rst_err", err, 0);
    check("rst_thr", thr, 8);
    check("rst_ctr", {ctr_row, ctr_col}, 0);
    check("rst_pos", {row, col}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit s, input bit v, input int t);
    int ec, er;
    bit st, ew, nw;
    @(negedge clk);
    sof = s;
    pix_valid = v;
    thr_in = 8'(t);
    #1;
    st = s && v;
    if (st || ph != 1) begin
      ec = 0; er = 0;
    end else begin
      ec = n % W; er = n / W;
    end
    ew = v && (ph == 1 || (ph == 0 && s));
    check("col", col, ec);
    check("row", row, er);
    check("lb_wren", lb_wren, ew);
    check("busy", busy, ph != 0);
    check("eof", eof, ph == 2);
    check("win_valid", win_valid, m_win);
    check("ctr_col", ctr_col, m_cc);
    check("ctr_row", ctr_row, m_cr);
    check("thr", thr, m_thr);
    check("err", err, m_err);
    if (win_valid) wcnt++;
    nw = ew && er >= 4 && ec >= 4;
    m_win = nw;
    if (nw) begin
      m_cc = ec - 2; m_cr = er - 2;
    end
    if (st) begin
      if (ph != 0) m_err = 1;
      ph = 1; n = 1; m_thr = t;
    end else if (ph == 1 && v) begin
      n++;
      if (n == W * H) ph = 2;
    end else if (ph == 2) begin
      ph = 0;
    end
  endtask

  task automatic run_frame(input int t0, input int t1,
                           input int gap, input bit abort);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        step((r == 0 && c == 0) || (abort && r == 2 && c == 3),
             1'b1, (r >= 3) ? t1 : t0);
      end
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, t1);
    end
    if (abort)
      for (int k = 0; k < 20; k++) step(1'b0, 1'b1, t1);
    step(1'b0, 1'b0, t1);
    step(1'b0, 1'b0, t1);
  endtask

  initial begin
    model_reset();
    wcnt = 0;
    do_reset();

    wcnt = 0;
    run_frame(20, 50, 0, 1'b0);
    check("wincnt_cont", wcnt, 8);
    wcnt = 0;
    run_frame(50, 50, 3, 1'b0);
    check("wincnt_gap", wcnt, 8);
    run_frame(20, 20, 0, 1'b1);
    check("abort_err", err, 1);

    do_reset();
    for (int i = 0; i < 37; i++)
      step(i == 0, 1'b1, 33);
    do_reset();
    wcnt = 0;
    run_frame(20, 20, 1, 1'b0);
    check("wincnt_after_rst", wcnt, 8);

    for (int i = 0; i < 3000; i++) begin
      bit s, v;
      if (i % 700 == 350) do_reset();
      v = ($urandom % 4) != 0;
      s = (ph == 0) ? (($urandom % 6) == 0)
                    : (($urandom % 300) == 0);
      step(s, v, int'($urandom % 256));
    end

    @(negedge clk);
    sof = 1'b0;
    pix_valid = 1'b0;
    for (int i = 0; i <= 2048; i++) begin
      @(negedge clk);
      w_sof = (i == 0);
      w_pv = 1'b1;
      #1;
      if (i == 1023) check("w_col_max", {w_row, w_col}, 1023);
      if (i == 1024) check("w_wrap1", {w_row, w_col}, 13'd1 << 13);
      if (i == 2047) check("w_col_r1", {w_row, w_col},
                           (13'd1 << 13) | 1023);
      if (i == 2048) check("w_wrap2", {w_row, w_col}, 13'd2 << 13);
    end
    @(negedge clk);
    w_pv = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nbad);
    $finish;
  end

endmodule

// File: doc/csct_ctrl.md
CSCT_CTRL -- requirements
Module: csct_ctrl

Interface
REQ-001 Parameter IMG_W, default 640: active pixels per line; legal range 5..1024.
REQ-002 Parameter IMG_H, default 480: active lines per frame; legal range 5..4096.
REQ-003 Parameter WIN, default 5: census window edge; fixed at 5 in this revision.
REQ-004 Port clk  in  1: pixel clock (25 MHz); all logic on its rising edge.
REQ-005 Port rst_n  in  1: reset; asynchronous, active-low.
REQ-006 Port sof  in  1: start-of-frame strobe, coincident with the first pixel of a frame.
REQ-007 Port pix_valid  in  1: an input pixel is present this cycle.
REQ-008 Port thr_in  in  8: requested census threshold T.
REQ-009 Port col  out  13: column of the pixel presented this cycle, driven to the window datapath and line-buffer addressing.
REQ-010 Port row  out  13: row of the pixel presented this cycle.
REQ-011 Port lb_wren  out  1: line-buffer write enable.
REQ-012 Port thr  out  8: frame-stable threshold driven to the datapath.
REQ-013 Port win_valid  out  1: datapath census output is a full window this cycle.
REQ-014 Port ctr_col / ctr_row  out  13 each: window-centre coordinate qualified by win_valid.
REQ-015 Port eof  out  1: one-cycle end-of-frame pulse.
REQ-016 Port busy  out  1: a frame is in progress.
REQ-017 Port err  out  1: sticky protocol-error flag.

Function
REQ-018 States: IDLE, FILL, ACTIVE, DONE, with 2-bit encoding.
- IDLE: waits for sof.
- FILL: rows 0..WIN-2.
- ACTIVE: rows WIN-1..IMG_H-1.
- DONE: lasts exactly one cycle.
REQ-019 IDLE -> FILL on sof&pix_valid; that pixel is accepted as (row 0, col 0).
- pix_valid without sof in IDLE is ignored.
- sof without pix_valid in IDLE is ignored.
REQ-020 col/row are combinational from the counter registers plus sof.
- In IDLE, and on an accepted sof pixel, they present 0/0.
- Otherwise they present the current counter values.
REQ-021 Each accepted pixel advances the counters:
- col increments by 1.
- At col=IMG_W-1, col wraps to 0 and row increments.
- Gaps with pix_valid=0 (blanking) freeze both counters.
REQ-022 FILL -> ACTIVE when row wraps from WIN-2 to WIN-1.
REQ-023 ACTIVE -> DONE when the pixel at (IMG_H-1, IMG_W-1) is accepted.
REQ-024 DONE -> IDLE unconditionally; eof=1 during DONE only.
REQ-025 lb_wren = pix_valid & (state is FILL or ACTIVE, or IDLE with sof).
REQ-026 thr is loaded from thr_in on each accepted sof and is stable for the rest of the frame; reset value 8.
REQ-027 win_valid is a register. It is set in the cycle after an accepted pixel at row>=WIN-1 and col>=WIN-1; otherwise it is 0. This matches the 1-cycle window-register latency of the datapath.
REQ-028 ctr_col/ctr_row register (col-2, row-2) of that same pixel, with the same 1-cycle latency.
- Both hold their value when win_valid=0.
- They never go negative, because win_valid gates them.
REQ-029 busy=1 in FILL, ACTIVE and DONE.
REQ-030 sof&pix_valid while in FILL or ACTIVE is a protocol error:
- set err;
- abort the current frame, with no eof;
- restart at (row 0, col 0) in FILL, loading thr.
REQ-031 A sof in DONE is a protocol error: set err, and accept that pixel as a new frame start (DONE -> FILL).
REQ-032 err stays set until reset.
REQ-033 Counters are 13 bits and never exceed IMG_W-1 / IMG_H-1, so no wrap past the limits is possible.
REQ-034 Line-buffer addressing uses col[9:0]; IMG_W<=1024 guarantees no aliasing.

Reset
REQ-035 rst_n low asynchronously forces:
- state=IDLE;
- counters=0;
- win_valid=0, eof=0, err=0;
- ctr_col=0, ctr_row=0;
- thr=8.
REQ-036 Reset mid-frame discards the frame; no eof is produced.
REQ-037 Line-buffer contents are not cleared. Stale data is masked, because win_valid stays 0 until WIN-1 fresh rows have been written.
REQ-038 Reset deassertion takes effect only at the next clk edge.

Structure
REQ-039 A shared package csct_pkg holds:
- the state encoding;
- COORD_W=13;
- LB_ADDR_W=10;
- THR_DEFAULT=8;
- WIN=5.
REQ-040 One sub-module, csct_coord_cnt, implements the col/row counter pair with wrap and hold; the FSM and output registers live in csct_ctrl.

Verification
Directed scenarios; IMG_W=8 and IMG_H=6 unless stated.
REQ-041 Continuous valid frame starting with sof, thr_in=20:
- the first win_valid appears the cycle after pixel (4,4), with ctr=(2,2);
- exactly 2x4=8 win_valid cycles occur;
- eof appears 1 cycle after pixel (5,7);
- thr=20 throughout.
REQ-042 Same frame with pix_valid=0 for 3 cycles after every line:
- the counters hold during the gaps;
- the win_valid count is still 8;
- lb_wren is 0 during the gaps.
REQ-043 sof asserted at pixel (2,3) of a frame:
- err=1;
- no eof;
- col/row = 0/0 that cycle;
- the next pixels count from (0,1).
REQ-044 rst_n pulsed low at (4,5):
- all outputs go to their reset values immediately;
- the next frame's first win_valid appears only after row 4.
REQ-045 thr_in changed mid-frame from 20 to 50: thr stays 20 until the next sof, then becomes 50.
REQ-046 IMG_W=1024: col wraps from 1023 to 0, and row increments exactly once per 1024 accepted pixels.
